// File: rtl/la_ulpi_phy.sv
// la_ulpi_phy: PHY-side ULPI responder.
// Decodes link TXCMDs (transmit, register write, register read), queues transmit bytes
// for a line serializer through a 2-entry FIFO, turns line receive activity into ULPI
// RX data / RXCMD bytes, and holds the function control register (0x04, with set/clear
// aliases at 0x05/0x06).
// Ports:
//   clk, reset                       sole clock, synchronous active-high reset
//   ulpi_data_in, ulpi_stp           link-driven bus value and stop
//   ulpi_dir, ulpi_nxt               PHY bus ownership and throttle
//   ulpi_data_out, ulpi_oen          PHY-driven bus value and pad enable
//   tx_valid, tx_data, tx_ready      byte stream to the serializer
//   tx_eop, tx_abort                 one-cycle end-of-packet / abort pulses
//   rx_active, rx_valid, rx_data, rx_error, linestate   line receiver inputs
//   func_ctrl                        live value of register 0x04
module la_ulpi_phy #(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009,
  parameter logic [7:0]  FUNC_RESET = 8'h41
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ulpi_data_in,
  input  logic       ulpi_stp,
  output logic       ulpi_dir,
  output logic       ulpi_nxt,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_oen,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       tx_eop,
  output logic       tx_abort,
  input  logic       rx_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  input  logic [1:0] linestate,
  output logic [7:0] func_ctrl
);

  typedef enum logic [3:0] {
    StIdle, StTxData, StTxDrain, StRegwAck, StRegwData, StRegwStp, StRegrAck,
    StRegrTurn, StRegrData, StRxTurn, StRxData, StRxLast, StLsTurn, StLsCmd,
    StTurnBack
  } state_e;

  state_e      state_q, state_d;
  logic        dir_q, dir_d, nxt_q, nxt_d, oen_q, oen_d;
  logic [7:0]  dout_q, dout_d;
  logic        eop_q, eop_d, abort_q, abort_d;
  logic        stp_ff_q, stp_ff_d;   // stp-cycle data was FFh: end with abort
  logic        first_q, first_d;     // next push is the PID byte
  logic [3:0]  pid_q, pid_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  func_q, func_d;
  logic [1:0]  ls_q, ls_d;           // last linestate reported to the link
  logic [7:0]  fifo_q [2];
  logic [7:0]  fifo_d [2];
  logic        wr_q, wr_d, rd_q, rd_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        push, pop;
  logic [7:0]  push_data, rd_val, rxcmd;

  // rxevent: 01 active, 11 active+error, 00 inactive
  assign rxcmd = {2'b00, rx_active & rx_error, rx_active, 2'b00, linestate};

  always_comb begin
    case (addr_q)
      6'h00:               rd_val = VENDOR_ID[7:0];
      6'h01:               rd_val = VENDOR_ID[15:8];
      6'h02:               rd_val = PRODUCT_ID[7:0];
      6'h03:               rd_val = PRODUCT_ID[15:8];
      6'h04, 6'h05, 6'h06: rd_val = func_q;
      default:             rd_val = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = 1'b0;
    nxt_d     = 1'b0;
    oen_d     = 1'b0;
    dout_d    = 8'h00;
    eop_d     = 1'b0;
    abort_d   = 1'b0;
    stp_ff_d  = stp_ff_q;
    first_d   = first_q;
    pid_d     = pid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    func_d    = func_q;
    ls_d      = ls_q;
    push      = 1'b0;
    push_data = ulpi_data_in;
    pop       = (cnt_q != 2'd0) && tx_ready;

    unique case (state_q)
      StIdle: begin
        if (rx_active) begin
          // Receive wins; any command this cycle is left unacknowledged for a retry.
          state_d = StRxTurn;
          dir_d   = 1'b1;
          nxt_d   = 1'b1;
        end else if (linestate != ls_q) begin
          state_d = StLsTurn;
          dir_d   = 1'b1;
        end else begin
          unique case (ulpi_data_in[7:6])
            2'b01: begin
              state_d = StTxData;
              nxt_d   = 1'b1;
              first_d = 1'b1;
              pid_d   = ulpi_data_in[3:0];
            end
            2'b10: begin
              state_d = StRegwAck;
              nxt_d   = 1'b1;
              addr_d  = ulpi_data_in[5:0];
            end
            2'b11: begin
              state_d = StRegrAck;
              nxt_d   = 1'b1;
              addr_d  = ulpi_data_in[5:0];
            end
            default: ;
          endcase
        end
      end
      StTxData: begin
        if (ulpi_stp) begin
          state_d  = StTxDrain;
          stp_ff_d = (ulpi_data_in == 8'hFF);
        end else if (nxt_q) begin
          push = 1'b1;
          if (first_q) push_data = {~pid_q, pid_q};
          first_d = 1'b0;
        end
      end
      StTxDrain: ;
      StRegwAck: begin
        if (ulpi_stp) begin
          state_d = StIdle;
        end else begin
          state_d = StRegwData;
          nxt_d   = 1'b1;
        end
      end
      StRegwData: begin
        if (ulpi_stp) begin
          state_d = StIdle;
        end else begin
          state_d = StRegwStp;
          wdata_d = ulpi_data_in;
        end
      end
      StRegwStp: begin
        if (ulpi_stp) begin
          state_d = StIdle;
          case (addr_q)
            6'h04:   func_d = wdata_q;
            6'h05:   func_d = func_q | wdata_q;
            6'h06:   func_d = func_q & ~wdata_q;
            default: ;
          endcase
        end
      end
      StRegrAck: begin
        state_d = StRegrTurn;
        dir_d   = 1'b1;
      end
      StRegrTurn: begin
        state_d = StRegrData;
        dir_d   = 1'b1;
        oen_d   = 1'b1;
        dout_d  = rd_val;
      end
      StRxTurn, StRxData: begin
        dir_d = 1'b1;
        oen_d = 1'b1;
        if (!rx_active) begin
          state_d = StRxLast;
          dout_d  = rxcmd;
          ls_d    = linestate;
        end else if (rx_valid) begin
          state_d = StRxData;
          nxt_d   = 1'b1;
          dout_d  = rx_data;
        end else begin
          state_d = StRxData;
          dout_d  = rxcmd;
          ls_d    = linestate;
        end
      end
      StLsTurn: begin
        state_d = StLsCmd;
        dir_d   = 1'b1;
        oen_d   = 1'b1;
        dout_d  = rxcmd;
        ls_d    = linestate;
      end
      StRegrData, StRxLast, StLsCmd: state_d = StTurnBack;
      StTurnBack: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    fifo_d = fifo_q;
    if (push) fifo_d[wr_q] = push_data;
    wr_d  = wr_q ^ push;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    // Throttle so the next cycle's push can never overflow the 2-entry FIFO.
    if (state_q == StTxData && !ulpi_stp) nxt_d = (cnt_d <= 2'd1);

    if (state_q == StTxDrain && cnt_d == 2'd0) begin
      state_d = StIdle;
      eop_d   = ~stp_ff_q;
      abort_d = stp_ff_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      dir_q    <= 1'b0;
      nxt_q    <= 1'b0;
      oen_q    <= 1'b0;
      dout_q   <= 8'h00;
      eop_q    <= 1'b0;
      abort_q  <= 1'b0;
      stp_ff_q <= 1'b0;
      first_q  <= 1'b0;
      pid_q    <= 4'h0;
      addr_q   <= 6'h00;
      wdata_q  <= 8'h00;
      func_q   <= FUNC_RESET;
      ls_q     <= 2'b00;
      fifo_q   <= '{8'h00, 8'h00};
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      nxt_q    <= nxt_d;
      oen_q    <= oen_d;
      dout_q   <= dout_d;
      eop_q    <= eop_d;
      abort_q  <= abort_d;
      stp_ff_q <= stp_ff_d;
      first_q  <= first_d;
      pid_q    <= pid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      func_q   <= func_d;
      ls_q     <= ls_d;
      fifo_q   <= fifo_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ulpi_dir      = dir_q;
  assign ulpi_nxt      = nxt_q;
  assign ulpi_oen      = oen_q;
  assign ulpi_data_out = dout_q;
  assign tx_valid      = (cnt_q != 2'd0);
  assign tx_data       = fifo_q[rd_q];
  assign tx_eop        = eop_q;
  assign tx_abort      = abort_q;
  assign func_ctrl     = func_q;

endmodule

// File: tb/tb_la_ulpi_phy.sv
// Directed bench for la_ulpi_phy. Inputs change 1 ns after the rising edge and outputs
// are sampled at the same point, so each step() shows the registered response to the
// inputs that were present at that edge.
module tb_la_ulpi_phy;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ulpi_data_in;
  logic       ulpi_stp;
  logic       ulpi_dir, ulpi_nxt, ulpi_oen;
  logic [7:0] ulpi_data_out;
  logic       tx_valid, tx_ready, tx_eop, tx_abort;
  logic [7:0] tx_data;
  logic       rx_active, rx_valid, rx_error;
  logic [7:0] rx_data;
  logic [1:0] linestate;
  logic [7:0] func_ctrl;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  la_ulpi_phy dut (
    .clk          (clk),
    .reset        (reset),
    .ulpi_data_in (ulpi_data_in),
    .ulpi_stp     (ulpi_stp),
    .ulpi_dir     (ulpi_dir),
    .ulpi_nxt     (ulpi_nxt),
    .ulpi_data_out(ulpi_data_out),
    .ulpi_oen     (ulpi_oen),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .tx_eop       (tx_eop),
    .tx_abort     (tx_abort),
    .rx_active    (rx_active),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_error     (rx_error),
    .linestate    (linestate),
    .func_ctrl    (func_ctrl)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [5:0] addr, input logic [7:0] data);
    ulpi_data_in = {2'b10, addr};
    step();
    check_eq("regw_ack_nxt", ulpi_nxt, 1);
    step();
    check_eq("regw_data_nxt", ulpi_nxt, 1);
    ulpi_data_in = data;
    step();
    ulpi_data_in = 8'h00;
    ulpi_stp     = 1'b1;
    step();
    ulpi_stp = 1'b0;
  endtask

  task automatic reg_read(input logic [5:0] addr, input logic [7:0] exp);
    ulpi_data_in = {2'b11, addr};
    step();
    check_eq("regr_c1_nxt_dir", {ulpi_nxt, ulpi_dir}, 2'b10);
    ulpi_data_in = 8'h00;
    step();
    check_eq("regr_c2_dir_oen", {ulpi_dir, ulpi_oen}, 2'b10);
    step();
    check_eq("regr_c3_dir_oen", {ulpi_dir, ulpi_oen}, 2'b11);
    check_eq("regr_c3_data", ulpi_data_out, exp);
    step();
    check_eq("regr_c4_dir", ulpi_dir, 0);
    step();
  endtask

  // Link sends TXCMD 44h (PID B4h), then AAh, BBh, then stp with stp_byte.
  task automatic tx_run(input logic [7:0] stp_byte, input logic exp_abort);
    logic [7:0] link_bytes [3];
    logic [7:0] exp_bytes [3];
    int         idx, pops, eops, aborts, occ;
    logic       done, stp_sent, pre_nxt, pre_pop, was_push;
    logic [7:0] pre_data;
    link_bytes = '{8'h44, 8'hAA, 8'hBB};
    exp_bytes  = '{8'hB4, 8'hAA, 8'hBB};
    idx = 0; pops = 0; eops = 0; aborts = 0; occ = 0;
    done = 1'b0; stp_sent = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (idx < 3) begin
        ulpi_data_in = link_bytes[idx];
        ulpi_stp     = 1'b0;
      end else if (!stp_sent) begin
        ulpi_data_in = stp_byte;
        ulpi_stp     = 1'b1;
        stp_sent     = 1'b1;
      end else begin
        ulpi_data_in = 8'h00;
        ulpi_stp     = 1'b0;
      end
      tx_ready = (cyc % 2) == 1;
      pre_nxt  = ulpi_nxt;
      pre_pop  = tx_valid & tx_ready;
      pre_data = tx_data;
      was_push = pre_nxt && (idx < 3);
      step();
      occ = occ + (was_push ? 1 : 0) - (pre_pop ? 1 : 0);
      check_eq("tx_fifo_overrun", (occ <= 2) ? 1 : 0, 1);
      if (pre_pop) begin
        if (pops < 3) check_eq("tx_byte", pre_data, exp_bytes[pops]);
        pops++;
      end
      if (was_push) idx++;
      if (tx_eop) eops++;
      if (tx_abort) aborts++;
      if (tx_eop || tx_abort) done = 1'b1;
    end
    ulpi_stp = 1'b0;
    ulpi_data_in = 8'h00;
    check_eq("tx_finished", done, 1);
    check_eq("tx_pop_count", pops, 3);
    check_eq("tx_eop_count", eops, exp_abort ? 0 : 1);
    check_eq("tx_abort_count", aborts, exp_abort ? 1 : 0);
    step();
    check_eq("tx_pulse_once", {tx_eop, tx_abort, tx_valid}, 3'b000);
    tx_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ulpi_data_in = 8'h00; ulpi_stp = 1'b0; tx_ready = 1'b0;
    rx_active = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'h00;
    linestate = 2'b00;
    step();
    step();
    reset = 1'b0;
    check_eq("rst_dir_nxt_oen", {ulpi_dir, ulpi_nxt, ulpi_oen}, 3'b000);
    check_eq("rst_data_out", ulpi_data_out, 8'h00);
    check_eq("rst_tx", {tx_valid, tx_eop, tx_abort}, 3'b000);
    check_eq("rst_func", func_ctrl, 8'h41);
    step();

    // Register file
    reg_read(6'h01, 8'h04);
    reg_write(6'h05, 8'h02);
    check_eq("func_or_set", func_ctrl, 8'h43);
    reg_write(6'h06, 8'h41);
    check_eq("func_clear", func_ctrl, 8'h02);
    reg_write(6'h04, 8'h5A);
    check_eq("func_assign", func_ctrl, 8'h5A);
    reg_write(6'h07, 8'hFF);
    check_eq("func_other_addr", func_ctrl, 8'h5A);
    // stp right after the command ack: nothing written
    ulpi_data_in = 8'h84;
    step();
    ulpi_data_in = 8'h00;
    ulpi_stp     = 1'b1;
    step();
    ulpi_stp = 1'b0;
    step();
    check_eq("func_early_stp", func_ctrl, 8'h5A);
    reg_read(6'h00, 8'h24);
    reg_read(6'h02, 8'h09);
    reg_read(6'h03, 8'h00);
    reg_read(6'h04, 8'h5A);
    reg_read(6'h06, 8'h5A);
    reg_read(6'h07, 8'h00);

    // Transmit
    tx_run(8'h00, 1'b0);
    tx_run(8'hFF, 1'b1);

    // Receive collides with a TXCMD
    ulpi_data_in = 8'h43;
    rx_active    = 1'b1;
    step();
    check_eq("rx_turn_dir_oen", {ulpi_dir, ulpi_oen}, 2'b10);
    ulpi_data_in = 8'h00;
    rx_valid = 1'b1; rx_data = 8'h5A;
    step();
    check_eq("rx_byte0", {ulpi_dir, ulpi_oen, ulpi_nxt, ulpi_data_out}, {3'b111, 8'h5A});
    rx_valid = 1'b0;
    step();
    check_eq("rx_gap_rxcmd", {ulpi_nxt, ulpi_data_out}, {1'b0, 8'h10});
    rx_valid = 1'b1; rx_data = 8'h3C;
    step();
    check_eq("rx_byte1", {ulpi_nxt, ulpi_data_out}, {1'b1, 8'h3C});
    rx_valid = 1'b0; rx_error = 1'b1;
    step();
    check_eq("rx_err_rxcmd", {ulpi_nxt, ulpi_data_out}, {1'b0, 8'h30});
    rx_error = 1'b0; rx_active = 1'b0;
    step();
    check_eq("rx_end_rxcmd", {ulpi_dir, ulpi_nxt, ulpi_data_out}, {2'b10, 8'h00});
    step();
    check_eq("rx_turn_back", ulpi_dir, 0);
    step();
    check_eq("rx_no_tx", tx_valid, 0);

    // Linestate reporting
    linestate = 2'b01;
    step();
    check_eq("ls_turn", {ulpi_dir, ulpi_oen, ulpi_nxt}, 3'b100);
    step();
    check_eq("ls_rxcmd", {ulpi_dir, ulpi_oen, ulpi_nxt, ulpi_data_out}, {3'b110, 8'h01});
    step();
    check_eq("ls_back", ulpi_dir, 0);
    step();
    // Linestate change beats a register read command in the same cycle
    linestate    = 2'b00;
    ulpi_data_in = 8'hC1;
    step();
    check_eq("ls_prio", {ulpi_dir, ulpi_nxt}, 2'b10);
    ulpi_data_in = 8'h00;
    step();
    check_eq("ls_rxcmd0", {ulpi_oen, ulpi_data_out}, {1'b1, 8'h00});
    step();
    step();

    // Reset in the middle of a transmit
    tx_ready     = 1'b0;
    ulpi_data_in = 8'h44;
    step();
    step();
    ulpi_data_in = 8'hAA;
    step();
    check_eq("mid_tx_busy", tx_valid, 1);
    ulpi_data_in = 8'h00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_rst_dir_nxt", {ulpi_dir, ulpi_nxt}, 2'b00);
    check_eq("mid_rst_fifo", tx_valid, 0);
    check_eq("mid_rst_func", func_ctrl, 8'h41);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("mid_rst_no_eop", {tx_eop, tx_abort, tx_valid}, 3'b000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
